// File: rtl/rst_seq_ctrl.sv
// Multi-domain reset sequencer: synchronises lock/button/software triggers, holds all domains,
// then releases them in order with a fixed gap. Optional button debounce: RST_SEQ_DEBOUNCE_EN.
module rst_seq_ctrl #(
   parameter int NumDomains     = 3,
   parameter int HoldCycles     = 255,
   parameter int StageGap       = 16,
   parameter int DebounceCycles = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  pll_locked_i,
   input  logic                  rst_btn_i,
   input  logic                  sw_rst_req_i,
   output logic [NumDomains-1:0] rst_no,
   output logic                  done_o,
   output logic [1:0]            cause_o
);

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int CntMax = max_int(max_int(HoldCycles, StageGap), DebounceCycles);
   localparam int CntW   = $clog2(CntMax + 1);
   localparam int IdxW   = $clog2(NumDomains + 1);

   localparam logic [1:0] CauseRst = 2'd0;
   localparam logic [1:0] CausePll = 2'd1;
   localparam logic [1:0] CauseBtn = 2'd2;
   localparam logic [1:0] CauseSw  = 2'd3;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [NumDomains-1:0] rst_n_q, rst_n_d;
   logic                  done_q, done_d;
   logic [1:0]            cause_q, cause_d;
   logic                  lock_s1, lock_s2, btn_s1, btn_s2;
   logic                  lock_seen_q, sw_q;
   logic                  btn_trig, pll_lost, trig;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_s1     <= 1'b0;
         lock_s2     <= 1'b0;
         btn_s1      <= 1'b0;
         btn_s2      <= 1'b0;
         lock_seen_q <= 1'b0;
         sw_q        <= 1'b0;
      end else begin
         lock_s1     <= pll_locked_i;
         lock_s2     <= lock_s1;
         btn_s1      <= rst_btn_i;
         btn_s2      <= btn_s1;
         lock_seen_q <= lock_seen_q | lock_s2;
         sw_q        <= sw_rst_req_i;
      end
   end

`ifdef RST_SEQ_DEBOUNCE_EN
   localparam int DebW = $clog2(DebounceCycles + 1);
   logic [DebW-1:0] deb_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         deb_cnt_q <= '0;
      end else if (!btn_s2) begin
         deb_cnt_q <= '0;
      end else if (deb_cnt_q != DebW'(DebounceCycles)) begin
         deb_cnt_q <= deb_cnt_q + 1'b1;
      end
   end

   assign btn_trig = (deb_cnt_q == DebW'(DebounceCycles));
`else
   assign btn_trig = btn_s2;
`endif

   // Lock low straight out of reset is the normal start-up case, not a PLL loss.
   assign pll_lost = ~lock_s2 & lock_seen_q;
   assign trig     = ~lock_s2 | btn_trig | sw_rst_req_i;
   assign cnt_inc  = (cnt_q == CntW'(CntMax)) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_n_d = rst_n_q;
      done_d  = done_q;
      cause_d = cause_q;
      if (trig) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         rst_n_d = '0;
         done_d  = 1'b0;
         if (pll_lost)          cause_d = CausePll;
         else if (btn_trig)     cause_d = CauseBtn;
         else if (sw_rst_req_i) cause_d = CauseSw;
      end else begin
         case (state_q)
            ST_HOLD: begin
               // The software request holds the count for one extra edge after it is seen.
               if (sw_q) begin
                  cnt_d = '0;
               end else if (cnt_inc == CntW'(HoldCycles)) begin
                  rst_n_d[0] = 1'b1;
                  cnt_d      = '0;
                  idx_d      = IdxW'(1);
                  if (NumDomains == 1) begin
                     state_d = ST_RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_RELEASE: begin
               if (cnt_inc == CntW'(StageGap)) begin
                  for (int k = 0; k < NumDomains; k++) begin
                     if (idx_q == IdxW'(k)) rst_n_d[k] = 1'b1;
                  end
                  idx_d = idx_q + 1'b1;
                  cnt_d = '0;
                  if (idx_q == IdxW'(NumDomains - 1)) begin
                     state_d = ST_RUN;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_RUN: begin
               rst_n_d = '1;
               done_d  = 1'b1;
            end
            default: state_d = ST_HOLD;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_n_q <= '0;
         done_q  <= 1'b0;
         cause_q <= CauseRst;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_n_q <= rst_n_d;
         done_q  <= done_d;
         cause_q <= cause_d;
      end
   end

   assign rst_no  = rst_n_q;
   assign done_o  = done_q;
   assign cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus random triggers, checked every edge against
// a model that derives release times from edges elapsed since the last blocking event.
module tb_rst_seq_ctrl;

   localparam int N = 3;
   localparam int H = 8;
   localparam int G = 4;
   localparam int D = 16;
`ifdef RST_SEQ_DEBOUNCE_EN
   localparam int BtnLat = 2 + D + 1;
`else
   localparam int BtnLat = 3;
`endif

   logic         clk = 1'b0;
   logic         rst_i, pll_locked_i, rst_btn_i, sw_rst_req_i;
   logic [N-1:0] rst_no;
   logic         done_o;
   logic [1:0]   cause_o;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   int         m_n, m_q, m_run;
   bit         m_seen, m_sw_prev;
   bit         lock_h[$];
   bit         btn_h[$];
   logic [1:0] m_cause;
   logic [N-1:0] m_rst;
   logic       m_done;

   rst_seq_ctrl #(
      .NumDomains     (N),
      .HoldCycles     (H),
      .StageGap       (G),
      .DebounceCycles (D)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .pll_locked_i (pll_locked_i),
      .rst_btn_i    (rst_btn_i),
      .sw_rst_req_i (sw_rst_req_i),
      .rst_no       (rst_no),
      .done_o       (done_o),
      .cause_o      (cause_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n       = 0;
      m_q       = 0;
      m_run     = 0;
      m_seen    = 1'b0;
      m_sw_prev = 1'b0;
      m_cause   = 2'd0;
      m_rst     = '0;
      m_done    = 1'b0;
      lock_h.delete();
      btn_h.delete();
   endtask

   // Called at each active edge with rst_i low.
   task automatic model_edge();
      bit lk, bt, bt_trig, lost, tr;
      m_n++;
      lock_h.push_back(pll_locked_i);
      btn_h.push_back(rst_btn_i);
      lk = (m_n >= 3) ? lock_h[m_n-3] : 1'b0;
      bt = (m_n >= 3) ? btn_h[m_n-3] : 1'b0;
`ifdef RST_SEQ_DEBOUNCE_EN
      bt_trig = (m_run >= D);
`else
      bt_trig = bt;
`endif
      lost = !lk && m_seen;
      tr   = !lk || bt_trig || sw_rst_req_i;
      if (tr) begin
         m_q = 0;
         if (lost)              m_cause = 2'd1;
         else if (bt_trig)      m_cause = 2'd2;
         else if (sw_rst_req_i) m_cause = 2'd3;
      end else if (m_sw_prev) begin
         m_q = 0;
      end else if (m_q < 100000) begin
         m_q++;
      end
      m_seen    = m_seen | lk;
      m_run     = bt ? m_run + 1 : 0;
      m_sw_prev = sw_rst_req_i;
      for (int k = 0; k < N; k++) m_rst[k] = (m_q >= H + k * G);
      m_done = (m_q >= H + (N - 1) * G);
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_i) model_reset();
      else       model_edge();
      @(negedge clk);
      check_eq("rst_no", rst_no, m_rst);
      check_eq("done", done_o, m_done);
      check_eq("cause", cause_o, m_cause);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int w;
      int lock_seg, btn_seg;
      rst_i        = 1'b1;
      pll_locked_i = 1'b1;
      rst_btn_i    = 1'b0;
      sw_rst_req_i = 1'b0;
      model_reset();

      // power-on
      steps(5);
      rst_i = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         step();
         if (e == 9)  check_eq("pwr_e9", rst_no, 3'b000);
         if (e == 10) check_eq("pwr_e10", rst_no, 3'b001);
         if (e == 13) check_eq("pwr_e13", rst_no, 3'b001);
         if (e == 14) check_eq("pwr_e14", rst_no, 3'b011);
         if (e == 17) check_eq("pwr_done17", done_o, 1'b0);
         if (e == 18) begin
            check_eq("pwr_e18", rst_no, 3'b111);
            check_eq("pwr_done18", done_o, 1'b1);
            check_eq("pwr_cause", cause_o, 2'd0);
         end
      end

      // software reset in RUN
      sw_rst_req_i = 1'b1;
      step();
      sw_rst_req_i = 1'b0;
      check_eq("sw_rst", rst_no, 3'b000);
      check_eq("sw_cause", cause_o, 2'd3);
      for (int e = 1; e <= 10; e++) begin
         step();
         if (e == 8) check_eq("sw_e8", rst_no, 3'b000);
         if (e == 9) check_eq("sw_e9", rst_no, 3'b001);
      end
      steps(10);

      // PLL loss and relock
      pll_locked_i = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         step();
         if (e == 2) check_eq("pll_e2", rst_no, 3'b111);
         if (e == 3) begin
            check_eq("pll_e3", rst_no, 3'b000);
            check_eq("pll_cause", cause_o, 2'd1);
         end
      end
      pll_locked_i = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         step();
         if (e == 9)  check_eq("relock_e9", rst_no, 3'b000);
         if (e == 10) check_eq("relock_e10", rst_no, 3'b001);
         if (e == 18) check_eq("relock_done", done_o, 1'b1);
      end

      // short button pulse, then a long press
      rst_btn_i = 1'b1;
      steps(10);
      rst_btn_i = 1'b0;
      steps(25);
`ifdef RST_SEQ_DEBOUNCE_EN
      check_eq("btn_short", rst_no, 3'b111);
`endif
      rst_btn_i = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         step();
         if (e == BtnLat - 1) check_eq("btn_pre", rst_no, 3'b111);
         if (e == BtnLat) begin
            check_eq("btn_hit", rst_no, 3'b000);
            check_eq("btn_cause", cause_o, 2'd2);
         end
         if (e == 30) check_eq("btn_held", rst_no, 3'b000);
      end
      rst_btn_i = 1'b0;
      steps(30);

      // software request arriving while only domain 0 is released
      sw_rst_req_i = 1'b1;
      step();
      sw_rst_req_i = 1'b0;
      w = 0;
      while (rst_no !== 3'b001 && w < 40) begin
         step();
         w++;
      end
      check_eq("wait_001", rst_no, 3'b001);
      sw_rst_req_i = 1'b1;
      step();
      sw_rst_req_i = 1'b0;
      check_eq("coll_sw_rst", rst_no, 3'b000);
      for (int e = 1; e <= 9; e++) begin
         step();
         if (e == 8) check_eq("coll_e8", rst_no, 3'b000);
         if (e == 9) check_eq("coll_e9", rst_no, 3'b001);
      end
      steps(20);

      // lock loss seen on the same edge as a software request
      pll_locked_i = 1'b0;
      steps(2);
      sw_rst_req_i = 1'b1;
      step();
      sw_rst_req_i = 1'b0;
      check_eq("coll_cause", cause_o, 2'd1);
      check_eq("coll_rst", rst_no, 3'b000);
      steps(5);
      pll_locked_i = 1'b1;

      // asynchronous reset with two domains released
      w = 0;
      while (rst_no !== 3'b011 && w < 60) begin
         step();
         w++;
      end
      check_eq("wait_011", rst_no, 3'b011);
      #2 rst_i = 1'b1;
      #1;
      check_eq("async_rst", rst_no, 3'b000);
      check_eq("async_done", done_o, 1'b0);
      check_eq("async_cause", cause_o, 2'd0);
      #1 rst_i = 1'b0;
      model_reset();
      steps(25);

      // random triggers
      lock_seg = 40;
      btn_seg  = 30;
      for (int i = 0; i < 800; i++) begin
         if (lock_seg == 0) begin
            pll_locked_i = ~pll_locked_i;
            lock_seg = pll_locked_i ? $urandom_range(20, 90) : $urandom_range(1, 8);
         end else begin
            lock_seg--;
         end
         if (btn_seg == 0) begin
            rst_btn_i = ~rst_btn_i;
            btn_seg = rst_btn_i ? $urandom_range(1, 30) : $urandom_range(20, 80);
         end else begin
            btn_seg--;
         end
         sw_rst_req_i = ($urandom_range(0, 99) < 2);
         step();
      end
      sw_rst_req_i = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
